// File: rtl/onehot_dispatch_decoder_pkg.sv
// Shared constants and decode helper for the one-hot dispatch decoder.
package onehot_dispatch_decoder_pkg;
   localparam int SEL_W_DEF  = 5;
   localparam int MODE_PULSE = 0;
   localparam int MODE_HOLD  = 1;

   // One bit of a one-hot decode: high when position pos is the selected index.
   function automatic logic onehot_bit(input int idx, input int pos);
      return idx == pos;
   endfunction
endpackage

// File: rtl/onehot_dispatch_decoder_onehot_decoder.sv
// Enable-gated combinational SEL_W -> 2^SEL_W one-hot decoder.
module onehot_decoder
   import onehot_dispatch_decoder_pkg::*;
#(
   parameter  int SEL_W = SEL_W_DEF,
   localparam int N     = 2**SEL_W
) (
   input  logic             i_en,
   input  logic [SEL_W-1:0] i_sel,
   output logic [N-1:0]     o_oh
);
   always_comb begin
      o_oh = '0;
      for (int i = 0; i < N; i++) o_oh[i] = i_en & onehot_bit(int'(i_sel), i);
   end
endmodule

// File: rtl/onehot_dispatch_decoder.sv
// Dispatches requests to one of N channels, tracks per-channel busy and an
// incremental busy count; out is a one-cycle pulse or held until done.
module onehot_dispatch_decoder
   import onehot_dispatch_decoder_pkg::*;
#(
   parameter  int SEL_W     = SEL_W_DEF,
   parameter  int HOLD_MODE = MODE_PULSE,
   localparam int N         = 2**SEL_W,
   localparam int CW        = SEL_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             req_valid,
   input  logic [SEL_W-1:0] req_sel,
   output logic             req_ready,
   input  logic [N-1:0]     done,
   output logic [N-1:0]     out,
   output logic [N-1:0]     busy,
   output logic [CW-1:0]    busy_cnt,
   output logic             all_busy
);
   logic [N-1:0]  r_busy, r_out;
   logic [CW-1:0] r_cnt;
   logic          r_all_busy;

   logic [N-1:0]  w_sel_oh, w_done_v, w_acc_oh, w_busy_nxt, w_out_nxt;
   logic          w_busy_hit, w_accept, w_acc_eff;
   logic [CW-1:0] w_pop, w_cnt_nxt;
   int            w_sum;

   onehot_decoder #(.SEL_W(SEL_W)) u_sel_dec (
      .i_en  (1'b1),
      .i_sel (req_sel),
      .o_oh  (w_sel_oh)
   );

   assign w_busy_hit = |(r_busy & w_sel_oh);
   assign req_ready  = en & rst_n & ~w_busy_hit;
   assign w_accept   = req_valid & req_ready;

   // A done on the channel being accepted cancels the acceptance.
   assign w_acc_eff  = w_accept & ~|(w_sel_oh & done);
   assign w_acc_oh   = w_sel_oh & {N{w_acc_eff}};
   assign w_done_v   = done & r_busy;
   assign w_busy_nxt = (r_busy & ~w_done_v) | w_acc_oh;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < N; i++) w_pop = w_pop + CW'(w_done_v[i]);
      w_sum = int'(r_cnt) + (w_acc_eff ? 1 : 0) - int'(w_pop);
      if (w_sum < 0)      w_cnt_nxt = '0;
      else if (w_sum > N) w_cnt_nxt = CW'(N);
      else                w_cnt_nxt = CW'(w_sum);
   end

   generate
      if (HOLD_MODE == MODE_HOLD) begin : g_hold
         logic [N-1:0] r_last;
         logic [N-1:0] w_last_nxt;
         assign w_last_nxt = w_accept ? w_sel_oh : r_last;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_last <= '0;
            else        r_last <= w_last_nxt;
         end
         assign w_out_nxt = en ? (w_busy_nxt & w_last_nxt) : '0;
      end else begin : g_pulse
         assign w_out_nxt = en ? w_acc_oh : '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_cnt      <= '0;
         r_all_busy <= 1'b0;
         r_out      <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_cnt      <= w_cnt_nxt;
         r_all_busy <= (w_cnt_nxt == CW'(N));
         r_out      <= w_out_nxt;
      end
   end

   assign out      = r_out;
   assign busy     = r_busy;
   assign busy_cnt = r_cnt;
   assign all_busy = r_all_busy;
endmodule

// File: tb/tb_onehot_dispatch_decoder.sv
// Drives a pulse-mode and a hold-mode instance in lockstep and compares both
// against a channel-level reference model.
module tb_onehot_dispatch_decoder;
   localparam int SEL_W = 5;
   localparam int N     = 32;

   logic          clk = 1'b0;
   logic          rst_n, en, req_valid;
   logic [4:0]    req_sel;
   logic [31:0]   done;
   logic          rdy0, rdy1, all0, all1;
   logic [31:0]   out0, out1, busy0, busy1;
   logic [5:0]    cnt0, cnt1;

   int tests = 0;
   int fails = 0;

   // reference model state
   bit [31:0] mb;
   int        mlast;
   bit [31:0] mo0;

   always #5 clk = ~clk;

   onehot_dispatch_decoder #(.SEL_W(SEL_W), .HOLD_MODE(0)) u_pulse (
      .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(rdy0), .done(done), .out(out0), .busy(busy0), .busy_cnt(cnt0),
      .all_busy(all0));

   onehot_dispatch_decoder #(.SEL_W(SEL_W), .HOLD_MODE(1)) u_hold (
      .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(rdy1), .done(done), .out(out1), .busy(busy1), .busy_cnt(cnt1),
      .all_busy(all1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outs();
      bit [31:0] eo1;
      int        ec;
      ec  = $countones(mb);
      eo1 = (mlast >= 0 && mb[mlast]) ? (32'h1 << mlast) : 32'h0;
      chk("out_pulse", out0, mo0);
      chk("out_hold", out1, eo1);
      chk("busy_pulse", busy0, mb);
      chk("busy_hold", busy1, mb);
      chk("cnt_pulse", cnt0, ec);
      chk("cnt_hold", cnt1, ec);
      chk("all_pulse", all0, ec == N);
      chk("all_hold", all1, ec == N);
   endtask

   // Hold-mode expected out kept as channel index; en low masks it for one edge.
   bit hold_en_gate;

   task automatic model_clear();
      mb = '0; mlast = -1; mo0 = '0; hold_en_gate = 1'b0;
   endtask

   task automatic cyc(input bit v, input int s, input logic [31:0] d, input bit e);
      bit exp_rdy, acc;
      req_valid = v; req_sel = s[4:0]; done = d; en = e;
      #1;
      exp_rdy = rst_n && e && !mb[s];
      chk("rdy_pulse", rdy0, exp_rdy);
      chk("rdy_hold", rdy1, exp_rdy);
      acc = v && exp_rdy;
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         for (int j = 0; j < N; j++) if (d[j]) mb[j] = 1'b0;
         mo0 = '0;
         if (acc) begin
            mlast = s;
            if (!d[s]) begin
               mb[s] = 1'b1;
               if (e) mo0 = 32'h1 << s;
            end
         end
         hold_en_gate = e;
      end
      #1;
      check_outs_gated();
   endtask

   task automatic check_outs_gated();
      int save;
      save = mlast;
      if (!hold_en_gate) mlast = -1;
      check_outs();
      mlast = save;
   endtask

   initial begin
      logic [31:0] d;
      int s;
      bit v, e;
      rst_n = 1'b0; en = 1'b0; req_valid = 1'b0; req_sel = '0; done = '0;
      model_clear();
      #12;
      check_outs();
      chk("rdy_in_reset", rdy0, 1'b0);
      rst_n = 1'b1;

      // first acceptance right after release, pulse out for one cycle
      cyc(1, 3, 0, 1);
      chk("pulse_ch3", out0, 32'h8);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);

      // hold: dispatch 7, done[7] ten cycles later
      cyc(1, 7, 0, 1);
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1);
      cyc(0, 0, 32'h80, 1);
      cyc(0, 0, 0, 1);

      // stall on busy channel 3 until its done clears it
      for (int i = 0; i < 4; i++) cyc(1, 3, 0, 1);
      cyc(1, 3, 32'h8, 1);
      cyc(1, 3, 0, 1);
      cyc(0, 0, 32'hFFFF_FFFF, 1);

      // fill every channel, stall, then recycle channel 0
      for (int i = 0; i < N; i++) cyc(1, i, 0, 1);
      cyc(1, 5, 0, 1);
      cyc(1, 0, 32'h1, 1);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 32'hFFFF_FFFF, 1);

      // accept 5 alongside done on busy 1 and 2, then spurious done on idle 9
      cyc(1, 1, 0, 1);
      cyc(1, 2, 0, 1);
      cyc(1, 5, 32'h6, 1);
      cyc(0, 0, 32'h200, 1);

      // en low: no acceptance, out zero, done still tracked
      cyc(1, 8, 0, 0);
      cyc(1, 8, 32'h20, 0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 32'hFFFF_FFFF, 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         v = 1'($urandom_range(0, 1));
         s = int'($urandom_range(0, N - 1));
         d = $urandom & $urandom & $urandom;
         if (v) d[s] = 1'b0;
         e = ($urandom_range(0, 9) != 0);
         cyc(v, s, d, e);
      end
      cyc(0, 0, 32'hFFFF_FFFF, 1);

      // reset mid-hold with four channels busy
      for (int i = 10; i < 14; i++) cyc(1, i, 0, 1);
      rst_n = 1'b0;
      #1;
      model_clear();
      check_outs();
      chk("rdy_async_rst", rdy1, 1'b0);
      cyc(1, 2, 32'h400, 1);
      cyc(0, 0, 32'hFFFF_FFFF, 1);
      rst_n = 1'b1;
      cyc(1, 0, 0, 1);
      chk("post_rst_pulse", out0, 32'h1);
      chk("post_rst_hold", out1, 32'h1);
      cyc(0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
